reflector_unit: RTL and testbench

REFLECTOR_UNIT -- requirements
Module: reflector_unit

---
 rtl/reflector_pkg.sv | 40 ++++
 rtl/reflector_fixed_rom.sv | 28 ++
 rtl/reflector_unit.sv | 153 +++++++++++++++
 tb/tb_reflector_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflector_pkg.sv
// Shared reflector constants: alphabet size, selector and config-state
// encodings, and the fixed B/C reflector wirings.
package reflector_pkg;

  localparam int N_SYM_DEF = 26;
  localparam int SYM_W_DEF = 5;
  localparam int WIRE_LEN  = 26;

  typedef enum logic [1:0] {
    SEL_B   = 2'd0,
    SEL_C   = 2'd1,
    SEL_D   = 2'd2,
    SEL_RSV = 2'd3
  } refl_sel_e;

  typedef enum logic [1:0] {
    CFG_IDLE  = 2'd0,
    CFG_CHECK = 2'd1,
    CFG_WRITE = 2'd2
  } cfg_state_e;

  typedef logic [4:0] wire_t;

  // YRUHQSLDPXNGOKMIEBFZCWVJAT
  localparam wire_t B_WIRING [WIRE_LEN] = '{
    5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11,
    5'd3,  5'd15, 5'd23, 5'd13, 5'd6,  5'd14, 5'd10,
    5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25, 5'd2,
    5'd22, 5'd21, 5'd9,  5'd0,  5'd19
  };

  // FVPJIAOYEDRZXWGCTKUQSBNMHL
  localparam wire_t C_WIRING [WIRE_LEN] = '{
    5'd5,  5'd21, 5'd15, 5'd9,  5'd8,  5'd0,  5'd14,
    5'd24, 5'd4,  5'd3,  5'd17, 5'd25, 5'd23, 5'd22,
    5'd6,  5'd2,  5'd19, 5'd10, 5'd20, 5'd16, 5'd18,
    5'd1,  5'd13, 5'd12, 5'd7,  5'd11
  };

endpackage

// File: rtl/reflector_fixed_rom.sv
// Combinational lookup of the hard-wired B and C reflectors.
// Codes beyond the wiring length and non-fixed selectors give zero.
module reflector_fixed_rom
  import reflector_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF
) (
  input  logic [1:0]       sel,
  input  logic [SYM_W-1:0] code,
  output logic [SYM_W-1:0] val
);

  logic [4:0] idx;

  assign idx = 5'(code);

  always_comb begin
    val = '0;
    if (int'(code) < WIRE_LEN) begin
      unique case (1'b1)
        (sel == SEL_B): val = SYM_W'(B_WIRING[idx]);
        (sel == SEL_C): val = SYM_W'(C_WIRING[idx]);
        default:        val = '0;
      endcase
    end
  end

endmodule

// File: rtl/reflector_unit.sv
// Reflector lookup with fixed B/C wirings and a programmable D table
// loaded one pair at a time through a small check-then-write FSM.
module reflector_unit
  import reflector_pkg::*;
#(
  parameter int N_SYM = N_SYM_DEF,
  parameter int SYM_W = SYM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       refl_sel,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SYM_W-1:0] cfg_a,
  input  logic [SYM_W-1:0] cfg_b,
  input  logic             cfg_clear,
  output logic             cfg_err,
  output logic             d_complete,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_val,
  output logic             out_err
);

  localparam int CNT_W = $clog2(N_SYM / 2 + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(N_SYM / 2);
  localparam logic [SYM_W:0]   LIM  = (SYM_W + 1)'(N_SYM);

  cfg_state_e state, state_nx;

  logic [SYM_W-1:0] a_q, b_q;
  logic [SYM_W-1:0] tab [N_SYM];
  logic [N_SYM-1:0] paired;
  logic [CNT_W-1:0] pair_cnt;

  logic cfg_fire, in_fire;
  logic reject, do_write;
  logic a_ok, b_ok, code_ok;

  logic [SYM_W-1:0] rom_val;
  logic [SYM_W-1:0] res_val;
  logic             res_err;

  assign cfg_fire   = cfg_valid && cfg_ready;
  assign in_ready   = (!out_valid || out_ready)
                   && (state == CFG_IDLE);
  assign in_fire    = in_valid && in_ready;
  assign d_complete = (pair_cnt == HALF);

  assign a_ok    = {1'b0, a_q} < LIM;
  assign b_ok    = {1'b0, b_q} < LIM;
  assign code_ok = {1'b0, in_code} < LIM;

  always_comb begin
    reject = 1'b1;
    if (a_ok && b_ok && (a_q != b_q))
      reject = paired[a_q] || paired[b_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CFG_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cfg_clear) begin
      state_nx = CFG_IDLE;
    end else begin
      unique case (state)
        CFG_IDLE:  if (cfg_fire) state_nx = CFG_CHECK;
        CFG_CHECK: state_nx = reject ? CFG_IDLE : CFG_WRITE;
        CFG_WRITE: state_nx = CFG_IDLE;
        default:   state_nx = CFG_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_ready = (state == CFG_IDLE);
    cfg_err   = (state == CFG_CHECK) && reject && !cfg_clear;
    do_write  = (state == CFG_WRITE) && !cfg_clear;
  end

  // Table data and the pending pair need no reset: paired flags gate them.
  always_ff @(posedge clk) begin
    if (cfg_fire) begin
      a_q <= cfg_a;
      b_q <= cfg_b;
    end
    if (do_write) begin
      tab[a_q] <= b_q;
      tab[b_q] <= a_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paired   <= '0;
      pair_cnt <= '0;
    end else if (cfg_clear) begin
      paired   <= '0;
      pair_cnt <= '0;
    end else if (do_write) begin
      paired[a_q] <= 1'b1;
      paired[b_q] <= 1'b1;
      pair_cnt    <= pair_cnt + 1'b1;
    end
  end

  reflector_fixed_rom #(
    .SYM_W (SYM_W)
  ) u_rom (
    .sel  (refl_sel),
    .code (in_code),
    .val  (rom_val)
  );

  always_comb begin
    res_val = '0;
    res_err = 1'b0;
    if (!code_ok || (refl_sel == SEL_RSV)) begin
      res_err = 1'b1;
    end else if (refl_sel == SEL_D) begin
      if (d_complete) begin
        res_val = tab[in_code];
      end else begin
        res_val = in_code;
        res_err = 1'b1;
      end
    end else begin
      res_val = rom_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_val   <= '0;
      out_err   <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_val   <= res_val;
      out_err   <= res_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reflector_unit.sv
// Directed plus randomized checks of reflector_unit against a
// string/array reference model of the reflector wirings and D table.
module tb_reflector_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] refl_sel;
  logic       cfg_valid, cfg_ready;
  logic [4:0] cfg_a, cfg_b;
  logic       cfg_clear, cfg_err, d_complete;
  logic       in_valid, in_ready;
  logic [4:0] in_code;
  logic       out_valid, out_ready;
  logic [4:0] out_val;
  logic       out_err;

  int checks = 0;
  int errors = 0;

  string B_STR = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  string C_STR = "FVPJIAOYEDRZXWGCTKUQSBNMHL";

  int m_tab [26];
  bit m_pair [26];
  int m_cnt;

  always #5 clk = ~clk;

  reflector_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .refl_sel   (refl_sel),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .cfg_clear  (cfg_clear),
    .cfg_err    (cfg_err),
    .d_complete (d_complete),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_val    (out_val),
    .out_err    (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_cnt = 0;
    for (int i = 0; i < 26; i++) m_pair[i] = 1'b0;
  endtask

  task automatic ref_lookup(input int sel, input int code,
                            output int v, output int e);
    v = 0;
    e = 1;
    if (code < 26 && sel != 3) begin
      e = 0;
      if (sel == 0) v = int'(B_STR[code]) - 65;
      else if (sel == 1) v = int'(C_STR[code]) - 65;
      else if (m_cnt == 13) v = m_tab[code];
      else begin
        v = code;
        e = 1;
      end
    end
  endtask

  function automatic bit would_reject(input int a, input int b);
    if (a == b) return 1'b1;
    if (a >= 26 || b >= 26) return 1'b1;
    return m_pair[a] || m_pair[b];
  endfunction

  task automatic lookup(input int sel, input int code);
    int v, e;
    ref_lookup(sel, code, v, e);
    refl_sel  = 2'(sel);
    in_code   = 5'(code);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 chk("lk_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("lk_valid", out_valid, 1);
    chk("lk_val", out_val, v);
    chk("lk_err", out_err, e);
  endtask

  task automatic cfg_write(input int a, input int b);
    bit rej;
    rej = would_reject(a, b);
    chk("cfg_ready_pre", cfg_ready, 1);
    cfg_a     = 5'(a);
    cfg_b     = 5'(b);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("cfg_ready_busy", cfg_ready, 0);
    chk("cfg_err", cfg_err, rej);
    step();
    if (!rej) begin
      chk("cfg_ready_wr", cfg_ready, 0);
      step();
      m_tab[a]  = b;
      m_tab[b]  = a;
      m_pair[a] = 1'b1;
      m_pair[b] = 1'b1;
      m_cnt++;
    end
    chk("cfg_ready_post", cfg_ready, 1);
    chk("cfg_err_pulse", cfg_err, 0);
    chk("d_complete", d_complete, m_cnt == 13);
  endtask

  task automatic clear_all();
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
    model_clear();
    chk("clr_d_complete", d_complete, 0);
  endtask

  initial begin
    int v, e;
    int p [26];
    rst_n     = 1'b1;
    refl_sel  = 2'd0;
    cfg_valid = 1'b0;
    cfg_a     = '0;
    cfg_b     = '0;
    cfg_clear = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b1;
    model_clear();

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_d_complete", d_complete, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    step();

    lookup(0, 0);
    lookup(1, 0);

    // Back-to-back burst: one result per cycle.
    refl_sel  = 2'd0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 26; i++) begin
      in_code = 5'(i);
      step();
      ref_lookup(0, i, v, e);
      chk("burst_valid", out_valid, 1);
      chk("burst_val", out_val, v);
    end
    in_valid = 1'b0;
    step();
    chk("burst_drain", out_valid, 0);

    // Backpressure with a second request waiting.
    out_ready = 1'b0;
    refl_sel  = 2'd0;
    in_code   = 5'd3;
    in_valid  = 1'b1;
    step();
    refl_sel = 2'd1;
    in_code  = 5'd4;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_val", out_val, 7);
      chk("bp_err", out_err, 0);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    chk("bp_val_held", out_val, 7);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_rel", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_val", out_val, 8);
    step();
    chk("bp_empty", out_valid, 0);

    // Programmable table: disjoint pairs, check before and after last.
    clear_all();
    for (int k = 0; k < 12; k++) cfg_write(2 * k, 2 * k + 1);
    lookup(2, 7);
    cfg_write(24, 25);
    lookup(2, 7);
    lookup(2, 24);
    lookup(2, 28);

    // Rejected pairs leave the count unchanged.
    clear_all();
    cfg_write(0, 1);
    cfg_write(3, 3);
    cfg_write(2, 30);
    cfg_write(0, 5);
    for (int k = 1; k < 13; k++) cfg_write(2 * k, 2 * k + 1);
    lookup(2, 13);

    // Clear wins over a simultaneous pair write.
    clear_all();
    cfg_write(0, 1);
    cfg_write(2, 3);
    cfg_a     = 5'd10;
    cfg_b     = 5'd11;
    cfg_valid = 1'b1;
    cfg_clear = 1'b1;
    step();
    cfg_valid = 1'b0;
    cfg_clear = 1'b0;
    model_clear();
    chk("clrwr_ready", cfg_ready, 1);
    chk("clrwr_err", cfg_err, 0);
    chk("clrwr_d_complete", d_complete, 0);
    step();
    chk("clrwr_ready2", cfg_ready, 1);
    chk("clrwr_err2", cfg_err, 0);
    cfg_write(10, 11);
    cfg_write(0, 1);

    // Random pair attempts, then a random full matching and lookups.
    clear_all();
    for (int i = 0; i < 12; i++)
      cfg_write($urandom_range(0, 31), $urandom_range(0, 31));
    for (int i = 0; i < 20; i++)
      lookup($urandom_range(0, 3), $urandom_range(0, 31));
    clear_all();
    for (int i = 0; i < 26; i++) p[i] = i;
    for (int i = 25; i > 0; i--) begin
      int j, t;
      j    = $urandom_range(0, i);
      t    = p[i];
      p[i] = p[j];
      p[j] = t;
    end
    for (int k = 0; k < 13; k++) cfg_write(p[2 * k], p[2 * k + 1]);
    for (int i = 0; i < 60; i++)
      lookup($urandom_range(0, 3), $urandom_range(0, 31));

    // Asynchronous reset in the middle of a burst.
    out_ready = 1'b1;
    refl_sel  = 2'd0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_code = 5'(i + 5);
      step();
    end
    chk("mid_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_val", out_val, 0);
    chk("arst_out_err", out_err, 0);
    chk("arst_d_complete", d_complete, 0);
    chk("arst_cfg_ready", cfg_ready, 1);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
    step();
    lookup(0, 25);
    lookup(2, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
